// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory geometry and scanner state encoding
package mem_pkg;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } scan_state_t;

endpackage

// File: rtl/mem_max_scanner.sv
// rtl/mem_max_scanner.sv - scans the data memory for max/index/sum and writes the max back
module mem_max_scanner
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    dst_addr,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             mem_we,
  output logic             mem_read,
  input  logic [DW-1:0]    mem_rdata,
  output logic             busy,
  output logic             done,
  output logic [DW-1:0]    max_val,
  output logic [AW-1:0]    max_idx,
  output logic [DW+AW-1:0] sum
);

  // Counter value of the last word; the counter is one bit wider than the
  // address so the scan end never aliases address 0.
  localparam logic [AW:0] LAST_CNT = (AW + 1)'(DEPTH - 1);

  scan_state_t      state;
  logic [AW:0]      cnt;
  logic [AW-1:0]    dst_q;
  logic [DW-1:0]    acc_max;
  logic [AW-1:0]    acc_idx;
  logic [DW+AW-1:0] acc_sum;

  logic [DW-1:0]    nxt_max;
  logic [AW-1:0]    nxt_idx;
  logic [DW+AW-1:0] nxt_sum;

  // Accumulator update for the word currently on mem_rdata; word 0 loads, later words compare strictly so ties keep the first index.
  always_comb begin
    nxt_max = acc_max;
    nxt_idx = acc_idx;
    nxt_sum = acc_sum + {{AW{1'b0}}, mem_rdata};
    if (cnt == '0) begin
      nxt_max = mem_rdata;
      nxt_idx = '0;
      nxt_sum = {{AW{1'b0}}, mem_rdata};
    end else if (mem_rdata > acc_max) begin
      nxt_max = mem_rdata;
      nxt_idx = cnt[AW-1:0];
    end
  end

  assign busy = (state != IDLE);

  // Scan FSM with registered memory-side and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dst_q     <= '0;
      acc_max   <= '0;
      acc_idx   <= '0;
      acc_sum   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_read  <= 1'b0;
      done      <= 1'b0;
      max_val   <= '0;
      max_idx   <= '0;
      sum       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          mem_we    <= 1'b0;
          mem_wdata <= '0;
          mem_read  <= 1'b0;
          mem_addr  <= '0;
          if (start) begin
            dst_q    <= dst_addr;
            cnt      <= '0;
            acc_max  <= '0;
            acc_idx  <= '0;
            acc_sum  <= '0;
            mem_read <= 1'b1;
            mem_addr <= '0;
            state    <= READ;
          end
        end
        READ: begin
          acc_max <= nxt_max;
          acc_idx <= nxt_idx;
          acc_sum <= nxt_sum;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            // Write back the max including the final word just sampled.
            mem_read  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= dst_q;
            mem_wdata <= nxt_max;
            state     <= WRITE;
          end else begin
            mem_addr <= AW'(cnt + 1'b1);
          end
        end
        WRITE: begin
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          max_val   <= acc_max;
          max_idx   <= acc_idx;
          sum       <= acc_sum;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
